// File: rtl/reg_file_pkg.sv
// Shared register-file types and constants for writeback sources and the arbiter.
package reg_file_pkg;

   localparam int unsigned DEF_ADDRESS_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH    = 32;
   localparam int unsigned ZERO_REG          = 0;

   // One writeback request as produced by an execute/memory source.
   typedef struct packed {
      logic                         valid;
      logic [DEF_ADDRESS_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0]    data;
   } wb_req_t;

endpackage

// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback request bus plus register-file write port.
// master: writeback sources / environment; slave: the arbiter.
interface reg_file_wb_arbiter_if
   import reg_file_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) ();

   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
   logic [NUM_REQ-1:0]               req_ready;
   logic                             we3;
   logic [ADDRESS_WIDTH-1:0]         a3;
   logic [DATA_WIDTH-1:0]            wd3;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, we3, a3, wd3
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, we3, a3, wd3
   );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot request arbiter. Round-robin with a registered pointer when
// WB_ARB_RR_EN is defined; otherwise stateless fixed priority (lowest index).
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
`ifdef WB_ARB_RR_EN
   input  logic               clk,
   input  logic               rst,
`endif
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant_c
);

`ifdef WB_ARB_RR_EN
   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             found;
   logic [PTR_W-1:0] idx;
   int unsigned      pos;
   int unsigned      nxt;

   // Search from ptr upward (wrapping); first requester wins, ptr moves past it.
   always_comb begin
      grant_c = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = '0;
      pos     = 0;
      nxt     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = 32'(ptr_q) + 32'(k);
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = PTR_W'(pos);
         if (enable && !found && req[idx]) begin
            found        = 1'b1;
            grant_c[idx] = 1'b1;
            nxt          = pos + 1;
            if (nxt == NUM_REQ) nxt = 0;
            ptr_d        = PTR_W'(nxt);
         end
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   logic found;

   // Fixed priority: lowest valid index wins.
   always_comb begin
      grant_c = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (enable && !found && req[i]) begin
            found      = 1'b1;
            grant_c[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port among NUM_REQ sources.
// Build option: WB_ARB_RR_EN selects round-robin (else fixed priority).
module reg_file_wb_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = reg_file_pkg::DEF_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = reg_file_pkg::DEF_DATA_WIDTH,
   parameter int unsigned NUM_REQ       = 2
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 stall,
   reg_file_wb_arbiter_if.slave wb
);
   import reg_file_pkg::*;

   logic                     en_c;
   logic [NUM_REQ-1:0]       grant_c;
   logic                     we3_q, we3_d;
   logic [ADDRESS_WIDTH-1:0] a3_q, a3_d;
   logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
   logic [ADDRESS_WIDTH-1:0] addr_c;

   // Grants are suppressed during reset and pipeline stall.
   assign en_c = !stall && !rst;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
`ifdef WB_ARB_RR_EN
      .clk     (clk),
      .rst     (rst),
`endif
      .req     (wb.req_valid),
      .enable  (en_c),
      .grant_c (grant_c)
   );

   assign wb.req_ready = grant_c;

   // Select the granted payload; writes to x0 are accepted but not performed.
   always_comb begin
      we3_d  = 1'b0;
      a3_d   = a3_q;
      wd3_d  = wd3_q;
      addr_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_c[i]) begin
            addr_c = wb.req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (addr_c != ADDRESS_WIDTH'(ZERO_REG)) begin
               we3_d = 1'b1;
               a3_d  = addr_c;
               wd3_d = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Write-port register; reset discards any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         we3_q <= 1'b0;
         a3_q  <= '0;
         wd3_q <= '0;
      end else begin
         we3_q <= we3_d;
         a3_q  <= a3_d;
         wd3_q <= wd3_d;
      end
   end

   assign wb.we3 = we3_q;
   assign wb.a3  = a3_q;
   assign wb.wd3 = wd3_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Randomized bench for reg_file_wb_arbiter against a transaction-level model.
module tb_reg_file_wb_arbiter;
   import reg_file_pkg::*;

   localparam int unsigned NR = 2;
   localparam int unsigned AW = DEF_ADDRESS_WIDTH;
   localparam int unsigned DW = DEF_DATA_WIDTH;

   logic clk = 1'b0;
   logic rst;
   logic stall;

   always #5 clk = ~clk;

   reg_file_wb_arbiter_if #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

   reg_file_wb_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .NUM_REQ       (NR)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .wb    (wb_if.slave)
   );

   wb_req_t req [NR];

   // reference model state
`ifdef WB_ARB_RR_EN
   int m_ptr = 0;
`endif
   logic          exp_we;
   logic [AW-1:0] exp_a3;
   logic [DW-1:0] exp_wd3;
   bit            have_exp = 1'b0;
   bit            port_known = 1'b0;
   logic [NR-1:0] last_g = '0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Who should win this cycle, straight from the arbitration rules.
   function automatic logic [NR-1:0] model_grant();
      logic [NR-1:0] g = '0;
      int idx;
      if (rst || stall) return g;
      for (int k = 0; k < NR; k++) begin
`ifdef WB_ARB_RR_EN
         idx = (m_ptr + k) % NR;
`else
         idx = k;
`endif
         if (req[idx].valid) begin
            g[idx] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         wb_if.req_valid[i]             = req[i].valid;
         wb_if.req_addr[i*AW +: AW]     = req[i].addr;
         wb_if.req_data[i*DW +: DW]     = req[i].data;
      end
   endtask

   // One clock: check comb grant and registered port, then advance the model.
   task automatic step();
      logic [NR-1:0] g;
      drive();
      @(negedge clk);
      g = model_grant();
      chk("req_ready", 64'(wb_if.req_ready), 64'(g));
      if (have_exp) begin
         chk("we3", 64'(wb_if.we3), 64'(exp_we));
         if (port_known) begin
            chk("a3", 64'(wb_if.a3), 64'(exp_a3));
            chk("wd3", 64'(wb_if.wd3), 64'(exp_wd3));
         end
      end
      have_exp = 1'b1;
      exp_we   = 1'b0;
      if (rst) begin
`ifdef WB_ARB_RR_EN
         m_ptr = 0;
`endif
         exp_a3     = '0;
         exp_wd3    = '0;
         port_known = 1'b1;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
`ifdef WB_ARB_RR_EN
               m_ptr = (i + 1) % NR;
`endif
               if (req[i].addr != '0) begin
                  exp_we     = 1'b1;
                  exp_a3     = req[i].addr;
                  exp_wd3    = req[i].data;
                  port_known = 1'b1;
               end else begin
                  port_known = 1'b0;
               end
            end
         end
      end
      last_g = g;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i].valid = v;
      req[i].addr  = a;
      req[i].data  = d;
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      set_req(0, 1'b1, AW'(3), 32'h0000_0033);
      set_req(1, 1'b1, AW'(4), 32'h0000_0044);
      // reset held with both requesting
      step();
      step();
      rst = 1'b0;
      // contention
      set_req(0, 1'b1, AW'(1), 32'h11);
      set_req(1, 1'b1, AW'(2), 32'h22);
      repeat (5) step();
      // single write
      set_req(1, 1'b0, AW'(0), 32'h0);
      set_req(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
      step();
      set_req(0, 1'b0, AW'(0), 32'h0);
      step();
      step();
      // x0 drop
      set_req(1, 1'b1, AW'(0), 32'hFFFF_FFFF);
      step();
      set_req(1, 1'b0, AW'(0), 32'h0);
      step();
      step();
      // stall with both valid after a grant to req0
      set_req(0, 1'b1, AW'(7), 32'h77);
      step();
      set_req(1, 1'b1, AW'(8), 32'h88);
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      step();
      step();
      // reset mid-operation
      set_req(0, 1'b1, AW'(9), 32'h99);
      set_req(1, 1'b1, AW'(10), 32'hAA);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      // randomized traffic with withdrawals, stalls and occasional reset
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (last_g[i] || !req[i].valid) begin
               req[i].valid = 1'($urandom_range(0, 1));
               req[i].addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
               req[i].data  = DW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               req[i].valid = 1'b0;
            end
         end
         stall = ($urandom_range(0, 7) == 0);
         rst   = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;
      stall = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
